dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the riscx load/store path: the target end of the core's memory-access request.
//  Accepts one word request at a time over a valid/ready request channel.
//  Performs it on an internal byte-writable RAM after a programmable wait-state delay.
//  Returns read data or a completion on a valid/ready response channel.
//  Sits below the MEM stage; used in core-level sims and as the on-chip DMEM.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words; power of two
//  BASE_ADDR    32'h8000_0000  byte address of word 0
//  WAIT_CYCLES  0     extra cycles between accept and response (0..15)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req_valid_i  in   1      request valid
//  req_ready_o  out  1      request ready
//  req_addr_i   in   32     byte address
//  req_wen_i    in   1      1=store, 0=load
//  req_wmask_i  in   4      byte enables for store; ignored for load
//  req_wdata_i  in   `XLEN  store data, byte lane i = bits [8i+7:8i]
//  rsp_valid_o  out  1      response valid
//  rsp_ready_i  in   1      response ready
//  rsp_rdata_o  out  `XLEN  load data (0 for stores and errors)
//  rsp_err_o    out  1      access fault: misaligned or out of range
// BEHAVIOUR
//  Reset values: req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; FSM=IDLE; wait counter=0.
//  RAM contents are not reset.
//  Handshakes:
//   - Request accept = req_valid_i & req_ready_o at a rising edge.
//   - Response retire = rsp_valid_o & rsp_ready_i.
//   - While rsp_valid_o=1, rsp_rdata_o and rsp_err_o are held stable until retire.
//  FSM states:
//   - IDLE: req_ready_o=1. On accept, latch addr/wen/wmask/wdata.
//     WAIT_CYCLES==0 -> RESP; otherwise -> WAIT with cnt=WAIT_CYCLES-1.
//   - WAIT: req_ready_o=0, rsp_valid_o=0. Decrement cnt; at cnt==0 -> RESP.
//   - RESP: rsp_valid_o=1. req_ready_o = rsp_ready_i (combinational).
//     Retire without a new accept -> IDLE.
//     Retire with a simultaneous accept -> handled as an IDLE accept (back-to-back).
//     No retire -> stay in RESP.
//  Commit:
//   - The RAM access happens on the edge that enters RESP.
//   - Latency accept-edge to rsp_valid_o = 1+WAIT_CYCLES cycles.
//   - Load: rsp_rdata_o = RAM word.
//   - Store: bytes with wmask=1 are written; rsp_rdata_o=0.
//   - A store with wmask=4'b0000 is legal and writes nothing.
//  Error:
//   - Condition: addr[1:0]!=0, or (addr-BASE_ADDR) >= 4*DEPTH_WORDS.
//     Unsigned 32-bit subtraction, so addresses below BASE_ADDR wrap and fault.
//   - Effect: rsp_err_o=1, no RAM access, rsp_rdata_o=0; same latency as a normal access.
//  Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
//  Read after write: a load accepted after a store's response retires sees the new data.
//  Reset mid-operation:
//   - A request in WAIT is dropped with no RAM write and no response.
//   - A store already committed (in RESP) stays written.
// STRUCTURE
//  defines.v: FSM state encodings `DMEM_IDLE/`DMEM_WAIT/`DMEM_RESP; reuses `XLEN.
//  Sub-module dmem_ram: synchronous single-port RAM, DEPTH_WORDS x 32, 4 byte write enables, registered read.
//  dmem_responder holds the FSM, wait counter, request latch, address check, and response registers.
// TESTING
//  1 WAIT_CYCLES=0: store 0xDEADBEEF mask 1111 @0x8000_0010, then load @0x8000_0010
//    -> each rsp 1 cycle after accept; load rdata=0xDEADBEEF, err=0.
//  2 Byte mask: store 0x11223344 mask 0101 over 0xDEADBEEF, then load -> rdata=0xDE22BE44.
//  3 Errors: load @0x8000_0002 -> err=1, rdata=0.
//    Store @0x7FFF_FFFC and @BASE+4*DEPTH -> err=1; RAM unchanged.
//  4 WAIT_CYCLES=3, rsp_ready_i held 0 for 5 cycles
//    -> rsp_valid at accept+4; rdata/err stable; req_ready_o=0 until retire.
//  5 Back-to-back, rsp_ready_i=1, req_valid_i=1 continuously, WAIT_CYCLES=0
//    -> one retire per cycle after the first; no request lost or duplicated.
//  6 Assert rst during WAIT of a store (WAIT_CYCLES=4)
//    -> outputs return to reset values; a later load shows old data.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the riscx data-memory responder.
package dmem_responder_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Addresses below base wrap through the unsigned subtraction and fault too.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] span);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (off >= span);
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [3:0]                     wmask,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, programmable wait states,
// RAM access on entry to RESP, valid/ready response out.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     req_addr_i,
  input  logic            req_wen_i,
  input  logic [3:0]      req_wmask_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e          state;
  logic [3:0]      cnt;
  logic [31:0]     addr_q;
  logic            wen_q;
  logic [3:0]      wmask_q;
  logic [XLEN-1:0] wdata_q;
  logic            rsp_load_q;

  logic            accept;
  logic            commit;
  logic [31:0]     acc_addr;
  logic            acc_wen;
  logic [3:0]      acc_wmask;
  logic [XLEN-1:0] acc_wdata;
  logic            acc_err;
  logic [31:0]     acc_off;
  logic [XLEN-1:0] ram_rdata;
  logic            unused_off_bits;

  assign req_ready_o = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign commit      = ((state == ST_WAIT) && (cnt == 4'd0)) ||
                       (accept && (WAIT_CYCLES == 0));

  // With zero wait states the access is taken straight from the request bus.
  always_comb begin
    acc_addr  = req_addr_i;
    acc_wen   = req_wen_i;
    acc_wmask = req_wmask_i;
    acc_wdata = req_wdata_i;
    if (state == ST_WAIT) begin
      acc_addr  = addr_q;
      acc_wen   = wen_q;
      acc_wmask = wmask_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_err         = addr_fault(acc_addr, BASE_ADDR, SPAN);
  assign acc_off         = acc_addr - BASE_ADDR;
  assign unused_off_bits = ^{acc_off[31:AW+2], acc_off[1:0]};

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (commit && !acc_err),
    .we    (acc_wen),
    .wmask (acc_wmask),
    .addr  (acc_off[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register stays put until the next commit, so gating it
  // with the load flag keeps rdata stable for the whole response.
  assign rsp_rdata_o = rsp_load_q ? ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        wen_q   <= req_wen_i;
        wmask_q <= req_wmask_i;
        wdata_q <= req_wdata_i;
      end
      if (commit) begin
        state       <= ST_RESP;
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= acc_err;
        rsp_load_q  <= !acc_err && !acc_wen;
      end else if (accept) begin
        state       <= ST_WAIT;
        cnt         <= WAIT_INIT;
        rsp_valid_o <= 1'b0;
        rsp_err_o   <= 1'b0;
        rsp_load_q  <= 1'b0;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end else if ((state == ST_RESP) && rsp_ready_i) begin
        state       <= ST_IDLE;
        rsp_valid_o <= 1'b0;
        rsp_err_o   <= 1'b0;
        rsp_load_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 3 and 4 wait states.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst       [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        req_wen   [3];
  logic [3:0]  req_wmask [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr[0]), .req_wen_i(req_wen[0]), .req_wmask_i(req_wmask[0]),
    .req_wdata_i(req_wdata[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]));

  dmem_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr[1]), .req_wen_i(req_wen[1]), .req_wmask_i(req_wmask[1]),
    .req_wdata_i(req_wdata[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]));

  dmem_responder #(.WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_addr_i(req_addr[2]), .req_wen_i(req_wen[2]), .req_wmask_i(req_wmask[2]),
    .req_wdata_i(req_wdata[2]), .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]),
    .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready[k]), 32'd1);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid[k]), 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata[k], 32'd0);
    chk({tag, ".rsp_err"},   32'(rsp_err[k]), 32'd0);
  endtask

  task automatic send(input int k, input logic wen, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] wdata);
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wmask[k] = mask;
    req_wdata[k] = wdata;
  endtask

  // One full transaction: accept, measure latency in cycles, check, retire.
  task automatic xfer(input int k, input logic wen, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] wdata,
                      input int lat_exp, input logic err_exp,
                      input logic [31:0] rd_exp, input string tag);
    int lat;
    @(negedge clk);
    send(k, wen, addr, mask, wdata);
    chk({tag, ".req_ready"}, 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[k] && lat < 40);
    chk({tag, ".latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, ".err"},     32'(rsp_err[k]), 32'(err_exp));
    chk({tag, ".rdata"},   rsp_rdata[k], rd_exp);
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_addr[k] = '0; req_wen[k] = 1'b0;
      req_wmask[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_idle(0, "reset0");
    chk_idle(1, "reset3");
    chk_idle(2, "reset4");
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Zero wait states: full store then load.
    xfer(0, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1, 1'b0, 32'h0, "t1.st");
    xfer(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, "t1.ld");

    // Partial byte mask, then an all-zero mask that must not write.
    xfer(0, 1'b1, 32'h8000_0010, 4'b0101, 32'h1122_3344, 1, 1'b0, 32'h0, "t2.st");
    xfer(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 1, 1'b0, 32'hDE22_BE44, "t2.ld");
    xfer(0, 1'b1, 32'h8000_0010, 4'b0000, 32'hFFFF_FFFF, 1, 1'b0, 32'h0, "t2.st0");
    xfer(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0, 1, 1'b0, 32'hDE22_BE44, "t2.ld0");

    // Faults: misaligned, below base, one past the end; first/last words untouched.
    xfer(0, 1'b1, 32'h8000_0000, 4'hF, 32'hAAAA_0000, 1, 1'b0, 32'h0, "t3.init0");
    xfer(0, 1'b1, 32'h8000_0FFC, 4'hF, 32'h5555_FFFF, 1, 1'b0, 32'h0, "t3.initN");
    xfer(0, 1'b0, 32'h8000_0002, 4'h0, 32'h0, 1, 1'b1, 32'h0, "t3.misal");
    xfer(0, 1'b1, 32'h7FFF_FFFC, 4'hF, 32'h1234_5678, 1, 1'b1, 32'h0, "t3.below");
    xfer(0, 1'b1, 32'h8000_1000, 4'hF, 32'h8765_4321, 1, 1'b1, 32'h0, "t3.past");
    xfer(0, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 1, 1'b0, 32'hAAAA_0000, "t3.chk0");
    xfer(0, 1'b0, 32'h8000_0FFC, 4'h0, 32'h0, 1, 1'b0, 32'h5555_FFFF, "t3.chkN");

    // Three wait states with the response held off for five cycles.
    xfer(1, 1'b1, 32'h8000_0020, 4'hF, 32'hCAFE_F00D, 4, 1'b0, 32'h0, "t4.st");
    @(negedge clk);
    send(1, 1'b0, 32'h8000_0020, 4'h0, 32'h0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("t4.wait%0d.valid", c), 32'(rsp_valid[1]), 32'd0);
      chk($sformatf("t4.wait%0d.ready", c), 32'(req_ready[1]), 32'd0);
    end
    @(negedge clk);
    chk("t4.first.valid", 32'(rsp_valid[1]), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t4.hold%0d.valid", c), 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("t4.hold%0d.rdata", c), rsp_rdata[1], 32'hCAFE_F00D);
      chk($sformatf("t4.hold%0d.err", c),   32'(rsp_err[1]), 32'd0);
      chk($sformatf("t4.hold%0d.ready", c), 32'(req_ready[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    #1 chk("t4.ready_on_retire", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1 rsp_ready[1] = 1'b0;
    @(negedge clk);
    chk("t4.after.valid", 32'(rsp_valid[1]), 32'd0);

    // Back-to-back loads: one retire per cycle, each with its own data.
    for (int i = 0; i < 6; i++)
      xfer(0, 1'b1, 32'h8000_0100 + 32'(4*i), 4'hF, 32'h1000_0000 + 32'(i) * 32'h0101_0101,
           1, 1'b0, 32'h0, $sformatf("t5.fill%0d", i));
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    send(0, 1'b0, 32'h8000_0100, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t5.b2b%0d.valid", i), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("t5.b2b%0d.rdata", i), rsp_rdata[0], 32'h1000_0000 + 32'(i) * 32'h0101_0101);
      chk($sformatf("t5.b2b%0d.ready", i), 32'(req_ready[0]), 32'd1);
      if (i < 5) req_addr[0] = 32'h8000_0100 + 32'(4*(i+1));
      else       req_valid[0] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("t5.drain.valid", 32'(rsp_valid[0]), 32'd0);
    rsp_ready[0] = 1'b0;

    // Reset while a store sits in WAIT: dropped, old data survives.
    xfer(2, 1'b1, 32'h8000_0040, 4'hF, 32'h0BAD_CAFE, 5, 1'b0, 32'h0, "t6.old");
    @(negedge clk);
    send(2, 1'b1, 32'h8000_0040, 4'hF, 32'h1111_1111);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6.in_wait.ready", 32'(req_ready[2]), 32'd0);
    rst[2] = 1'b1;
    #1 chk_idle(2, "t6.rst");
    @(negedge clk);
    rst[2] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("t6.norsp%0d", c), 32'(rsp_valid[2]), 32'd0);
    end
    xfer(2, 1'b0, 32'h8000_0040, 4'h0, 32'h0, 5, 1'b0, 32'h0BAD_CAFE, "t6.ld");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
